bcd_updown_timer: RTL and testbench
===================================

// Module: bcd_updown_timer
// PURPOSE
//  Parametrised successor of the 60 s key-driven timer. It counts up or down in 0.1 s
//  steps, holding three BCD digits: tens, ones and tenths. The count runs between
//  00.0 and LIMIT.0 s with preset load, pause and a terminal-count policy.
//  It sits between the debounced board keys and the two 7-segment digits plus the
//  alarm LED. Key inputs are active-low; the block synchronises and edge-detects them.
// PARAMETERS
//  TICK_DIV  5_000_000  clk_50M cycles per 0.1 s tick (2..2^26).
//  LIMIT     59         Terminal value in whole seconds (1..99); the count tops out at LIMIT.0.
//  WRAP      0          0 = stop at terminal (DONE); 1 = wrap and keep counting.
// PORTS
//  clk_50M   in   1  System clock; all logic is on the rising edge.
//  rst       in   1  Synchronous reset, active-high.
//  en        in   1  Global enable; 0 freezes everything and ignores keys.
//  key0      in   1  Count-up key, active-low.
//  key1      in   1  Count-down key, active-low.
//  key2      in   1  Load-preset key, active-low.
//  pause     in   1  Level input; 1 holds the count and the prescaler phase.
//  ten       in   4  Preset tens digit (BCD).
//  one       in   4  Preset ones digit (BCD).
//  tens      out  4  Current tens digit (BCD).
//  ones      out  4  Current ones digit (BCD).
//  tenths    out  4  Current tenths digit (BCD).
//  out_ge    out  7  7-segment pattern for ones; active-low, bit order {g,f,e,d,c,b,a}.
//  out_xiao  out  7  7-segment pattern for tenths; same encoding as out_ge.
//  point     out  1  Decimal point after ones; active-low.
//  led       out  1  Terminal alarm, active-high.
// BEHAVIOUR
//  Reset
//   - state=IDLE, count=00.0, prescaler=0.
//   - tens/ones/tenths=0, out_ge=out_xiao=7'b1000000, point=0 (lit), led=0.
//   - Key synchronisers are reset to 1.
//  Key path
//   - Each key passes a 2-FF synchroniser, then a falling-edge detector.
//   - A press takes effect on the 3rd rising edge after the input falls.
//   - Priority for presses in the same cycle: key2 > key1 > key0.
//  States
//   - IDLE: holds the count.
//   - UP, DOWN: count on ticks.
//   - DONE: holds the terminal value, led=1.
//  Transitions
//   - key2, from any state: load {ten,one}.0 and go to IDLE; led=0; prescaler=0.
//     Digits above 9 clamp to 9; a value above LIMIT clamps to LIMIT.
//   - key0, from any state: go to UP; prescaler=0.
//     If the count equals LIMIT.0, restart from 00.0.
//   - key1, from any state: go to DOWN; prescaler=0.
//     If the count equals 00.0, reload the clamped preset (a 00 preset stays in IDLE).
//  Tick
//   - The prescaler advances only when en=1, pause=0 and state is UP or DOWN.
//   - A tick fires when prescaler==TICK_DIV-1, and the prescaler then returns to 0.
//   - The first tick fires TICK_DIV cycles after the mode change.
//  Counting
//   - UP: tenths 9->0 carries into ones; ones 9->0 carries into tens.
//   - DOWN: borrows mirror the UP carries.
//   - Digits never leave 0..9.
//  Terminal
//   - UP reaching LIMIT.0, or DOWN reaching 00.0, on a tick:
//     - WRAP=0: go to DONE, led=1.
//     - WRAP=1: on the next tick wrap to 00.0 (UP) or LIMIT.0 (DOWN), with led=1 for
//       exactly one cycle on the wrap.
//  Outputs
//   - All outputs are registered and update on the cycle after a tick, load or reset.
//  point
//   - In UP or DOWN: toggles every 5 ticks (1 Hz heartbeat).
//   - Otherwise: 0.
//  en=0
//   - State, count and prescaler hold; key presses are discarded; the synchronisers
//     keep running.
//  pause during DONE has no effect.
// CONFIGURATION
//  TIMER_BLINK_EN defined
//   - In DONE the prescaler keeps running; led toggles every 5 ticks, starting at 1.
//   - led returns to 0 on leaving DONE.
//  TIMER_BLINK_EN undefined
//   - led is a steady 1 in DONE.
//   - The prescaler is frozen in DONE.
// TESTING  (TICK_DIV=4, LIMIT=15, WRAP=0 unless stated)
//  1. Reset:
//     - Stimulus: rst=1 for 5 cycles, then release.
//     - Response: tens/ones/tenths=0, out_ge=out_xiao=7'b1000000, led=0, point=0.
//  2. Load with clamp:
//     - Stimulus: ten=1, one=9, pulse key2 low for 2 cycles.
//     - Response: count=15.0, state IDLE, no ticks afterwards.
//  3. Count up to terminal:
//     - Stimulus: load 14, then pulse key0.
//     - Response: 14.1 appears 4 cycles after the press takes effect; after 10 ticks
//       the count is 15.0 and led=1, and the count holds.
//  4. Count down with pause:
//     - Stimulus: load 00, key1 -> no change; then load 01, key1; hold pause=1 for
//       20 cycles mid-tick.
//     - Response: 00.9, 00.8, ... with the tick phase preserved across the pause;
//       00.0 -> DONE.
//  5. Wrap:
//     - Stimulus: WRAP=1, count up from 15.0.
//     - Response: tick -> 00.0, with led high for exactly 1 cycle.
//  6. Simultaneous keys and en:
//     - Stimulus: key0 and key1 pressed in the same cycle; separately, en=0 with key2
//       pulsed.
//     - Response: state DOWN for the simultaneous press; the key2 press under en=0 is
//       ignored and the count is unchanged.

Source files
------------

// File: rtl/bcd_updown_timer.sv
// bcd_updown_timer: three-digit BCD (tens.ones.tenths) up/down timer with
// preset load, pause, terminal alarm and 7-segment drive for ones/tenths.
// Keys are active-low and go through a 2-FF synchroniser plus a falling-edge
// detector, so a press acts on the 3rd rising edge after the key falls.
// Optional feature macro: TIMER_BLINK_EN (blinking alarm LED in DONE).
module bcd_updown_timer #(
   parameter int unsigned TICK_DIV = 5_000_000,
   parameter int unsigned LIMIT    = 59,
   parameter bit          WRAP     = 1'b0
) (
   input  logic       clk_50M,
   input  logic       rst,
   input  logic       en,
   input  logic       key0,
   input  logic       key1,
   input  logic       key2,
   input  logic       pause,
   input  logic [3:0] ten,
   input  logic [3:0] one,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [3:0] tenths,
   output logic [6:0] out_ge,
   output logic [6:0] out_xiao,
   output logic       point,
   output logic       led
);

   localparam int unsigned    PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [3:0]     LIM_T     = 4'(LIMIT / 10);
   localparam logic [3:0]     LIM_O     = 4'(LIMIT % 10);

   typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

   // active-low 7-segment, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // key synchroniser / edge detector, bit order {key2,key1,key0}
   logic [2:0] ks1_q, ks2_q, ks3_q;
   logic [2:0] press;

   state_t        state_q, state_d;
   logic [3:0]    tens_q, tens_d, ones_q, ones_d, tenths_q, tenths_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    hb_q, hb_d;          // ticks since last heartbeat toggle
   logic          point_q, point_d, led_q, led_d;
   logic [6:0]    ge_q, xiao_q;

   logic [3:0]    ten_c, one_c, pre_t, pre_o;
   logic [3:0]    inc_t, inc_o, inc_th, dec_t, dec_o, dec_th;
   logic          at_zero, at_lim, inc_lim, dec_zero, run, tick;

   // synchronisers free-run (also while en=0) so stale presses are dropped
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         ks1_q <= 3'b111;
         ks2_q <= 3'b111;
         ks3_q <= 3'b111;
      end else begin
         ks1_q <= {key2, key1, key0};
         ks2_q <= ks1_q;
         ks3_q <= ks2_q;
      end
   end

   assign press = ks3_q & ~ks2_q;

   // next-state: key actions (key2 > key1 > key0) take precedence over ticks
   always_comb begin
      state_d  = state_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      tenths_d = tenths_q;
      presc_d  = presc_q;
      hb_d     = hb_q;
      point_d  = point_q;
      // outside DONE the LED is only ever a one-cycle wrap pulse
      led_d    = (state_q == DONE) ? led_q : 1'b0;
      tick     = 1'b0;

      // preset clamp: digits to 9, then whole value to LIMIT (BCD order = numeric order)
      ten_c = (ten > 4'd9) ? 4'd9 : ten;
      one_c = (one > 4'd9) ? 4'd9 : one;
      if ({ten_c, one_c} > {LIM_T, LIM_O}) begin
         pre_t = LIM_T;
         pre_o = LIM_O;
      end else begin
         pre_t = ten_c;
         pre_o = one_c;
      end

      at_zero = (tens_q == 4'd0) && (ones_q == 4'd0) && (tenths_q == 4'd0);
      at_lim  = (tens_q == LIM_T) && (ones_q == LIM_O) && (tenths_q == 4'd0);

      // BCD increment; tens cannot pass 9 because LIMIT <= 99
      inc_t  = tens_q;
      inc_o  = ones_q;
      inc_th = tenths_q + 4'd1;
      if (tenths_q == 4'd9) begin
         inc_th = 4'd0;
         if (ones_q == 4'd9) begin
            inc_o = 4'd0;
            inc_t = tens_q + 4'd1;
         end else begin
            inc_o = ones_q + 4'd1;
         end
      end
      inc_lim = (inc_t == LIM_T) && (inc_o == LIM_O) && (inc_th == 4'd0);

      // BCD decrement; never applied at 00.0
      dec_t  = tens_q;
      dec_o  = ones_q;
      dec_th = tenths_q - 4'd1;
      if (tenths_q == 4'd0) begin
         dec_th = 4'd9;
         if (ones_q == 4'd0) begin
            dec_o = 4'd9;
            dec_t = tens_q - 4'd1;
         end else begin
            dec_o = ones_q - 4'd1;
         end
      end
      dec_zero = (dec_t == 4'd0) && (dec_o == 4'd0) && (dec_th == 4'd0);

`ifdef TIMER_BLINK_EN
      run = en && (((state_q == UP || state_q == DOWN) && !pause) || state_q == DONE);
`else
      run = en && !pause && (state_q == UP || state_q == DOWN);
`endif

      if (run) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      if (en && press[2]) begin
         state_d  = IDLE;
         tens_d   = pre_t;
         ones_d   = pre_o;
         tenths_d = 4'd0;
         presc_d  = '0;
         hb_d     = 3'd0;
         point_d  = 1'b0;
         led_d    = 1'b0;
      end else if (en && press[1]) begin
         state_d = DOWN;
         presc_d = '0;
         hb_d    = 3'd0;
         point_d = 1'b0;
         led_d   = 1'b0;
         if (at_zero) begin
            tens_d   = pre_t;
            ones_d   = pre_o;
            tenths_d = 4'd0;
            if ({pre_t, pre_o} == 8'h00) state_d = IDLE;
         end
      end else if (en && press[0]) begin
         state_d = UP;
         presc_d = '0;
         hb_d    = 3'd0;
         point_d = 1'b0;
         led_d   = 1'b0;
         if (at_lim) begin
            tens_d   = 4'd0;
            ones_d   = 4'd0;
            tenths_d = 4'd0;
         end
      end else if (tick) begin
         if (state_q == UP || state_q == DOWN) begin
            if (hb_q == 3'd4) begin
               hb_d    = 3'd0;
               point_d = ~point_q;
            end else begin
               hb_d = hb_q + 3'd1;
            end
         end
         case (state_q)
            UP: begin
               if (at_lim) begin
                  // only reachable with WRAP=1: terminal was held one tick
                  tens_d   = 4'd0;
                  ones_d   = 4'd0;
                  tenths_d = 4'd0;
                  led_d    = 1'b1;
               end else begin
                  tens_d   = inc_t;
                  ones_d   = inc_o;
                  tenths_d = inc_th;
                  if (inc_lim && !WRAP) begin
                     state_d = DONE;
                     hb_d    = 3'd0;
                     point_d = 1'b0;
                     led_d   = 1'b1;
                  end
               end
            end
            DOWN: begin
               if (at_zero) begin
                  tens_d   = LIM_T;
                  ones_d   = LIM_O;
                  tenths_d = 4'd0;
                  led_d    = 1'b1;
               end else begin
                  tens_d   = dec_t;
                  ones_d   = dec_o;
                  tenths_d = dec_th;
                  if (dec_zero && !WRAP) begin
                     state_d = DONE;
                     hb_d    = 3'd0;
                     point_d = 1'b0;
                     led_d   = 1'b1;
                  end
               end
            end
`ifdef TIMER_BLINK_EN
            DONE: begin
               if (hb_q == 3'd4) begin
                  hb_d  = 3'd0;
                  led_d = ~led_q;
               end else begin
                  hb_d = hb_q + 3'd1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // state, count and registered display outputs
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state_q  <= IDLE;
         tens_q   <= 4'd0;
         ones_q   <= 4'd0;
         tenths_q <= 4'd0;
         presc_q  <= '0;
         hb_q     <= 3'd0;
         point_q  <= 1'b0;
         led_q    <= 1'b0;
         ge_q     <= 7'b1000000;
         xiao_q   <= 7'b1000000;
      end else begin
         state_q  <= state_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         tenths_q <= tenths_d;
         presc_q  <= presc_d;
         hb_q     <= hb_d;
         point_q  <= point_d;
         led_q    <= led_d;
         ge_q     <= seg7(ones_d);
         xiao_q   <= seg7(tenths_d);
      end
   end

   assign tens     = tens_q;
   assign ones     = ones_q;
   assign tenths   = tenths_q;
   assign out_ge   = ge_q;
   assign out_xiao = xiao_q;
   assign point    = point_q;
   assign led      = led_q;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Bench for bcd_updown_timer: TICK_DIV=4, LIMIT=15. dut has WRAP=0, dut_w has
// WRAP=1; both share stimulus (every key2 load brings them back in step).
module tb_bcd_updown_timer;

   logic       clk, rst, en, key0, key1, key2, pause;
   logic [3:0] ten, one;
   logic [3:0] tens, ones, tenths, tens_w, ones_w, tenths_w;
   logic [6:0] ge, xiao, ge_w, xiao_w;
   logic       point, led, point_w, led_w;
   int         n_chk, n_pass;

   bcd_updown_timer #(.TICK_DIV(4), .LIMIT(15), .WRAP(1'b0)) dut (
      .clk_50M(clk), .rst(rst), .en(en), .key0(key0), .key1(key1), .key2(key2),
      .pause(pause), .ten(ten), .one(one), .tens(tens), .ones(ones), .tenths(tenths),
      .out_ge(ge), .out_xiao(xiao), .point(point), .led(led));

   bcd_updown_timer #(.TICK_DIV(4), .LIMIT(15), .WRAP(1'b1)) dut_w (
      .clk_50M(clk), .rst(rst), .en(en), .key0(key0), .key1(key1), .key2(key2),
      .pause(pause), .ten(ten), .one(one), .tens(tens_w), .ones(ones_w), .tenths(tenths_w),
      .out_ge(ge_w), .out_xiao(xiao_w), .point(point_w), .led(led_w));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic       rst, en, pause;
      logic [2:0] k;            // {key2,key1,key0} levels, active-low
      logic [3:0] ten, one;
      int         ncyc;
      logic [3:0] et, eo, eth;
      logic       eled, epnt;
   } vec_t;

   vec_t v[$];

   function automatic vec_t mk(input logic r, input logic e, input logic p,
                               input logic [2:0] k, input logic [3:0] tn, input logic [3:0] on,
                               input int n, input logic [3:0] et, input logic [3:0] eo,
                               input logic [3:0] eth, input logic el, input logic ep);
      vec_t x;
      x.rst = r; x.en = e; x.pause = p; x.k = k; x.ten = tn; x.one = on; x.ncyc = n;
      x.et = et; x.eo = eo; x.eth = eth; x.eled = el; x.epnt = ep;
      return x;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0: seg_of = 7'b1000000;  4'd1: seg_of = 7'b1111001;
         4'd2: seg_of = 7'b0100100;  4'd3: seg_of = 7'b0110000;
         4'd4: seg_of = 7'b0011001;  4'd5: seg_of = 7'b0010010;
         4'd6: seg_of = 7'b0000010;  4'd7: seg_of = 7'b1111000;
         4'd8: seg_of = 7'b0000000;  4'd9: seg_of = 7'b0010000;
         default: seg_of = 7'b1111111;
      endcase
   endfunction

   task automatic check(input string nm, input logic [3:0] at, input logic [3:0] ao,
                        input logic [3:0] ath, input logic al, input logic ap,
                        input logic [6:0] ag, input logic [6:0] ax,
                        input logic [3:0] et, input logic [3:0] eo, input logic [3:0] eth,
                        input logic el, input logic ep);
      logic [27:0] act, exp;
      act = {at, ao, ath, al, ap, ag, ax};
      exp = {et, eo, eth, el, ep, seg_of(eo), seg_of(eth)};
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h%h.%h led=%b pt=%b ge=%b xiao=%b, expected %h%h.%h led=%b pt=%b ge=%b xiao=%b",
                    nm, at, ao, ath, al, ap, ag, ax, et, eo, eth, el, ep, seg_of(eo), seg_of(eth));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // key low for two edges, then released; the action lands on the next edge
   task automatic press(input logic [2:0] k);
      {key2, key1, key0} = k;
      cyc(2);
      {key2, key1, key0} = 3'b111;
      cyc(1);
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst = 1'b1; en = 1'b1; pause = 1'b0; {key2, key1, key0} = 3'b111; ten = 4'd0; one = 4'd0;

      //          rst  en   pse  keys    ten    one    n   t  o  th led pt
      // reset
      v.push_back(mk(1, 1, 0, 3'b111, 4'd0, 4'd0,  5, 0, 0, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd0,  1, 0, 0, 0, 0, 0));
      // load 19 -> clamps to 15.0, then idle
      v.push_back(mk(0, 1, 0, 3'b011, 4'd1, 4'd9,  2, 0, 0, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd9,  1, 1, 5, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd9, 12, 1, 5, 0, 0, 0));
      // load 14, count up to terminal
      v.push_back(mk(0, 1, 0, 3'b011, 4'd1, 4'd4,  2, 1, 5, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4,  1, 1, 4, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b110, 4'd1, 4'd4,  2, 1, 4, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4,  1, 1, 4, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4,  3, 1, 4, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4,  1, 1, 4, 1, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4, 16, 1, 4, 5, 0, 1));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4, 20, 1, 5, 0, 1, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd4, 12, 1, 5, 0, 1, 0));
      // load 00, key1 at zero stays idle
      v.push_back(mk(0, 1, 0, 3'b011, 4'd0, 4'd0,  2, 1, 5, 0, 1, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd0,  1, 0, 0, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b101, 4'd0, 4'd0,  2, 0, 0, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd0,  1, 0, 0, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd0,  8, 0, 0, 0, 0, 0));
      // load 01, count down with a pause two cycles into a tick period
      v.push_back(mk(0, 1, 0, 3'b011, 4'd0, 4'd1,  2, 0, 0, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  1, 0, 1, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b101, 4'd0, 4'd1,  2, 0, 1, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  1, 0, 1, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  4, 0, 0, 9, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  2, 0, 0, 9, 0, 0));
      v.push_back(mk(0, 1, 1, 3'b111, 4'd0, 4'd1, 20, 0, 0, 9, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  1, 0, 0, 9, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  1, 0, 0, 8, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1, 32, 0, 0, 0, 1, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd1,  8, 0, 0, 0, 1, 0));
      // load 05, key0+key1 together -> DOWN wins
      v.push_back(mk(0, 1, 0, 3'b011, 4'd0, 4'd5,  2, 0, 0, 0, 1, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd5,  1, 0, 5, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b100, 4'd0, 4'd5,  2, 0, 5, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd5,  1, 0, 5, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd5,  4, 0, 4, 9, 0, 0));
      // en=0 freezes and drops a key2 press
      v.push_back(mk(0, 0, 0, 3'b011, 4'd1, 4'd2,  2, 0, 4, 9, 0, 0));
      v.push_back(mk(0, 0, 0, 3'b111, 4'd1, 4'd2,  1, 0, 4, 9, 0, 0));
      v.push_back(mk(0, 0, 0, 3'b111, 4'd1, 4'd2,  6, 0, 4, 9, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd1, 4'd2,  4, 0, 4, 8, 0, 0));
      // key2+key0 together -> load wins, stays idle
      v.push_back(mk(0, 1, 0, 3'b010, 4'd0, 4'd7,  2, 0, 4, 8, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd7,  1, 0, 7, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'd7,  6, 0, 7, 0, 0, 0));
      // non-BCD ones digit clamps to 9
      v.push_back(mk(0, 1, 0, 3'b011, 4'd0, 4'hC,  2, 0, 7, 0, 0, 0));
      v.push_back(mk(0, 1, 0, 3'b111, 4'd0, 4'hC,  1, 0, 9, 0, 0, 0));

      foreach (v[i]) begin
         rst = v[i].rst; en = v[i].en; pause = v[i].pause;
         {key2, key1, key0} = v[i].k; ten = v[i].ten; one = v[i].one;
         cyc(v[i].ncyc);
         check($sformatf("vec[%0d]", i), tens, ones, tenths, led, point, ge, xiao,
               v[i].et, v[i].eo, v[i].eth, v[i].eled, v[i].epnt);
      end

      // key0 at LIMIT.0 restarts from 00.0
      ten = 4'd1; one = 4'd5;
      press(3'b011);
      check("load15", tens, ones, tenths, led, point, ge, xiao, 1, 5, 0, 0, 0);
      press(3'b110);
      check("up_restart", tens, ones, tenths, led, point, ge, xiao, 0, 0, 0, 0, 0);
      check("up_restart_w", tens_w, ones_w, tenths_w, led_w, point_w, ge_w, xiao_w, 0, 0, 0, 0, 0);
      cyc(4);
      check("up_first_tick", tens, ones, tenths, led, point, ge, xiao, 0, 0, 1, 0, 0);

      // wrap: WRAP=1 holds 15.0 for a tick, then 00.0 with a one-cycle led pulse
      ten = 4'd1; one = 4'd4;
      press(3'b011);
      press(3'b110);
      cyc(40);
      check("stop_at_lim", tens, ones, tenths, led, point, ge, xiao, 1, 5, 0, 1, 0);
      check("wrap_at_lim", tens_w, ones_w, tenths_w, led_w, point_w, ge_w, xiao_w, 1, 5, 0, 0, 0);
      cyc(3);
      check("wrap_hold", tens_w, ones_w, tenths_w, led_w, point_w, ge_w, xiao_w, 1, 5, 0, 0, 0);
      cyc(1);
      check("wrap_tick", tens_w, ones_w, tenths_w, led_w, point_w, ge_w, xiao_w, 0, 0, 0, 1, 0);
      check("done_hold", tens, ones, tenths, led, point, ge, xiao, 1, 5, 0, 1, 0);
      cyc(1);
      check("wrap_led_drop", tens_w, ones_w, tenths_w, led_w, point_w, ge_w, xiao_w, 0, 0, 0, 0, 0);
      cyc(3);
      check("wrap_continue", tens_w, ones_w, tenths_w, led_w, point_w, ge_w, xiao_w, 0, 0, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
